// File: rtl/rv32_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// rv32_branch_resolve_unit
//
// Resolves RV32 conditional branches one cycle after acceptance, flags
// mispredictions against the fetch-time guess, and trains a table of 2-bit
// saturating counters (BHT) that also answers fetch-side predictions.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   pred_pc / pred_taken fetch-side lookup (combinational, BHT bit[1])
//   res_*               resolve request from execute, valid/ready handshake
//   flush               drops the held result and blocks accepts this cycle
//   out_*               registered result, valid/ready handshake
//   perf_branches       legal branches accepted (wrapping)
//   perf_mispredicts    legal mispredicted branches accepted (wrapping)
// -----------------------------------------------------------------------------
module rv32_branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [2:0]      res_funct3,
    input  logic [XLEN-1:0] res_rs1,
    input  logic [XLEN-1:0] res_rs2,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] res_target,
    input  logic            res_pred_taken,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic [XLEN-1:0] out_redirect_pc,
    output logic            out_illegal,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Counter table and result registers
    logic [1:0]      r_bht [BHT_ENTRIES];
    logic            r_out_valid;
    logic            r_out_taken;
    logic            r_out_mispredict;
    logic            r_out_illegal;
    logic [XLEN-1:0] r_out_redirect_pc;
    logic [31:0]     r_perf_branches;
    logic [31:0]     r_perf_mispredicts;

    logic            w_taken;
    logic            w_illegal;
    logic            w_mispredict;
    logic            w_accept;
    logic            w_res_ready;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_pc;
    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_res_idx;
    logic [1:0]      w_res_cnt;
    logic            w_unused;

    // Instructions are word aligned, so the index skips the two low PC bits.
    assign w_pred_idx = pred_pc[IDX_W+1:2];
    assign w_res_idx  = res_pc[IDX_W+1:2];
    assign pred_taken = r_bht[w_pred_idx][1];
    assign w_unused   = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (res_funct3)
            F3_BEQ:  w_taken = (res_rs1 == res_rs2);
            F3_BNE:  w_taken = (res_rs1 != res_rs2);
            F3_BLT:  w_taken = ($signed(res_rs1) <  $signed(res_rs2));
            F3_BGE:  w_taken = ($signed(res_rs1) >= $signed(res_rs2));
            F3_BLTU: w_taken = (res_rs1 <  res_rs2);
            F3_BGEU: w_taken = (res_rs1 >= res_rs2);
            default: w_illegal = 1'b1;
        endcase
    end

    // An illegal encoding never counts as a mispredict, whatever fetch guessed.
    assign w_mispredict  = !w_illegal && (w_taken != res_pred_taken);
    assign w_pc_plus4    = res_pc + {{(XLEN-3){1'b0}}, 3'b100};
    assign w_redirect_pc = w_taken ? res_target : w_pc_plus4;

    // Flush and reset both block acceptance; otherwise accept when the result
    // slot is empty or is being drained this cycle.
    assign w_res_ready = !rst && !flush && (!r_out_valid || out_ready);
    assign w_accept    = res_valid && w_res_ready;
    assign w_res_cnt   = r_bht[w_res_idx];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid        <= 1'b0;
            r_out_taken        <= 1'b0;
            r_out_mispredict   <= 1'b0;
            r_out_illegal      <= 1'b0;
            r_out_redirect_pc  <= '0;
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else if (w_accept) begin
            r_out_valid       <= 1'b1;
            r_out_taken       <= w_taken;
            r_out_mispredict  <= w_mispredict;
            r_out_illegal     <= w_illegal;
            r_out_redirect_pc <= w_redirect_pc;
            if (!w_illegal) begin
                r_perf_branches <= r_perf_branches + 32'd1;
                if (w_mispredict) begin
                    r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
                end
            end
        end else if (out_ready || flush) begin
            r_out_valid <= 1'b0;
        end
    end

    // NOTE: the counter table is reset explicitly because predictions must
    // start from weak-not-taken; this keeps it in flops rather than a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept && !w_illegal) begin
            if (w_taken && (w_res_cnt != 2'b11)) begin
                r_bht[w_res_idx] <= w_res_cnt + 2'd1;
            end else if (!w_taken && (w_res_cnt != 2'b00)) begin
                r_bht[w_res_idx] <= w_res_cnt - 2'd1;
            end
        end
    end

    assign res_ready        = w_res_ready;
    assign out_valid        = r_out_valid;
    assign out_taken        = r_out_taken;
    assign out_mispredict   = r_out_mispredict;
    assign out_illegal      = r_out_illegal;
    assign out_redirect_pc  = r_out_redirect_pc;
    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;

endmodule

// File: tb/tb_rv32_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_rv32_branch_resolve_unit
//
// Directed bench for rv32_branch_resolve_unit. Inputs change and outputs are
// sampled on the falling edge; the DUT updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_rv32_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_funct3;
    logic [31:0] res_rs1;
    logic [31:0] res_rs2;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic        out_mispredict;
    logic [31:0] out_redirect_pc;
    logic        out_illegal;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_funct3       (res_funct3),
        .res_rs1          (res_rs1),
        .res_rs2          (res_rs2),
        .res_pc           (res_pc),
        .res_target       (res_target),
        .res_pred_taken   (res_pred_taken),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_taken        (out_taken),
        .out_mispredict   (out_mispredict),
        .out_redirect_pc  (out_redirect_pc),
        .out_illegal      (out_illegal),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request; it is sampled at the next rising edge.
    task automatic drive(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic pt);
        res_funct3     = f3;
        res_rs1        = rs1;
        res_rs2        = rs2;
        res_pc         = pc;
        res_target     = tgt;
        res_pred_taken = pt;
        res_valid      = 1'b1;
    endtask

    // One request for exactly one rising edge; returns on the following falling edge.
    task automatic resolve(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] pc, input logic [31:0] tgt, input logic pt);
        drive(f3, rs1, rs2, pc, tgt, pt);
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic taken, input logic mis,
                                input logic ill, input logic [31:0] redir);
        check({tag, ".valid"},    {31'b0, out_valid},      32'd1);
        check({tag, ".taken"},    {31'b0, out_taken},      {31'b0, taken});
        check({tag, ".mispred"},  {31'b0, out_mispredict}, {31'b0, mis});
        check({tag, ".illegal"},  {31'b0, out_illegal},    {31'b0, ill});
        check({tag, ".redirect"}, out_redirect_pc,         redir);
    endtask

    initial begin
        rst            = 1'b1;
        pred_pc        = 32'h0000_0100;
        res_valid      = 1'b1;
        res_funct3     = 3'b000;
        res_rs1        = '0;
        res_rs2        = '0;
        res_pc         = '0;
        res_target     = '0;
        res_pred_taken = 1'b0;
        flush          = 1'b0;
        out_ready      = 1'b1;

        // Reset: held for two cycles, ready stays low even with valid high.
        @(negedge clk);
        check("rst.ready", {31'b0, res_ready}, 32'd0);
        @(negedge clk);
        check("rst.ready2", {31'b0, res_ready}, 32'd0);
        rst       = 1'b0;
        res_valid = 1'b0;
        #1;
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.redirect",  out_redirect_pc,    32'd0);
        check("rst.perf_br",   perf_branches,      32'd0);
        check("rst.perf_mis",  perf_mispredicts,   32'd0);
        check("rst.pred_100",  {31'b0, pred_taken}, 32'd0);
        check("idle.ready",    {31'b0, res_ready}, 32'd1);
        @(negedge clk);

        // Taken BNE predicted not-taken.
        resolve(3'b001, 32'd5, 32'd6, 32'h0000_0080, 32'h0000_1000, 1'b0);
        check_result("bne_mis", 1'b1, 1'b1, 1'b0, 32'h0000_1000);
        check("bne_mis.perf_br",  perf_branches,    32'd1);
        check("bne_mis.perf_mis", perf_mispredicts, 32'd1);

        // Illegal funct3: no taken, no mispredict, counters untouched.
        resolve(3'b010, 32'd5, 32'd5, 32'h0000_0080, 32'h0000_1000, 1'b1);
        check_result("illegal", 1'b0, 1'b0, 1'b1, 32'h0000_0084);
        check("illegal.perf_br",  perf_branches,    32'd1);
        check("illegal.perf_mis", perf_mispredicts, 32'd1);

        // All six conditions with rs1=-1 / 0xFFFFFFFF, rs2=1; fetch guessed not-taken.
        resolve(3'b000, 32'hFFFF_FFFF, 32'd1, 32'h0000_0200, 32'h0000_0180, 1'b0);
        check_result("beq",  1'b0, 1'b0, 1'b0, 32'h0000_0204);
        resolve(3'b001, 32'hFFFF_FFFF, 32'd1, 32'h0000_0200, 32'h0000_0180, 1'b0);
        check_result("bne",  1'b1, 1'b1, 1'b0, 32'h0000_0180);
        resolve(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h0000_0200, 32'h0000_0180, 1'b0);
        check_result("blt",  1'b1, 1'b1, 1'b0, 32'h0000_0180);
        resolve(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h0000_0200, 32'h0000_0180, 1'b0);
        check_result("bge",  1'b0, 1'b0, 1'b0, 32'h0000_0204);
        resolve(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h0000_0200, 32'h0000_0180, 1'b0);
        check_result("bltu", 1'b0, 1'b0, 1'b0, 32'h0000_0204);
        resolve(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h0000_0200, 32'h0000_0180, 1'b0);
        check_result("bgeu", 1'b1, 1'b1, 1'b0, 32'h0000_0180);
        check("conds.perf_br",  perf_branches,    32'd7);
        check("conds.perf_mis", perf_mispredicts, 32'd4);

        // Training at pc 0x40: first update is not visible in its own cycle.
        pred_pc = 32'h0000_0040;
        drive(3'b000, 32'd7, 32'd7, 32'h0000_0040, 32'h0000_0020, 1'b1);
        #1;
        check("train.no_bypass", {31'b0, pred_taken}, 32'd0);
        @(negedge clk);
        res_valid = 1'b0;
        check("train.t1.pred", {31'b0, pred_taken}, 32'd1);
        check_result("train.t1", 1'b1, 1'b0, 1'b0, 32'h0000_0020);
        resolve(3'b000, 32'd7, 32'd7, 32'h0000_0040, 32'h0000_0020, 1'b1);
        resolve(3'b000, 32'd7, 32'd7, 32'h0000_0040, 32'h0000_0020, 1'b1);
        resolve(3'b000, 32'd7, 32'd7, 32'h0000_0040, 32'h0000_0020, 1'b1);
        check("train.sat", {30'b0, dut.r_bht[16]}, 32'd3);
        resolve(3'b000, 32'd7, 32'd8, 32'h0000_0040, 32'h0000_0020, 1'b0);
        check("train.nt1.pred", {31'b0, pred_taken}, 32'd1);
        resolve(3'b000, 32'd7, 32'd8, 32'h0000_0040, 32'h0000_0020, 1'b0);
        check("train.nt2.pred", {31'b0, pred_taken}, 32'd0);
        check_result("train.nt2", 1'b0, 1'b0, 1'b0, 32'h0000_0044);
        check("train.perf_br", perf_branches, 32'd13);

        // Drain, then backpressure: result held, second request refused.
        @(negedge clk);
        check("drain.out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;
        resolve(3'b110, 32'd1, 32'd2, 32'h0000_0500, 32'h0000_0600, 1'b1);
        check_result("bp.first", 1'b1, 1'b0, 1'b0, 32'h0000_0600);
        drive(3'b000, 32'd1, 32'd2, 32'h0000_0700, 32'h0000_0800, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp.ready", {31'b0, res_ready}, 32'd0);
            check_result("bp.hold", 1'b1, 1'b0, 1'b0, 32'h0000_0600);
            @(negedge clk);
        end

        // Flush with a held result and a pending request: nothing accepted.
        flush = 1'b1;
        #1;
        check("flush.ready", {31'b0, res_ready}, 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        res_valid = 1'b0;
        check("flush.out_valid", {31'b0, out_valid}, 32'd0);
        check("flush.perf_br",   perf_branches,      32'd14);
        check("flush.perf_mis",  perf_mispredicts,   32'd4);
        out_ready = 1'b1;

        // PC wrap on the fall-through path.
        resolve(3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h0000_0010, 1'b0);
        check_result("wrap.pc", 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        check("wrap.perf_br", perf_branches, 32'd15);

        // Performance counter wrap.
        force dut.r_perf_branches = 32'hFFFF_FFFF;
        #1;
        release dut.r_perf_branches;
        #1;
        check("wrap.perf_preset", perf_branches, 32'hFFFF_FFFF);
        @(negedge clk);
        resolve(3'b001, 32'd1, 32'd2, 32'h0000_0900, 32'h0000_0a00, 1'b1);
        check("wrap.perf_br0",  perf_branches,    32'd0);
        check("wrap.perf_mis",  perf_mispredicts, 32'd4);

        // Reset mid-operation drops the held result and retrains the table.
        pred_pc = 32'h0000_0080;
        #1;
        check("pre_rst.pred_80", {31'b0, pred_taken}, 32'd1);
        check("pre_rst.valid",   {31'b0, out_valid},  32'd1);
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst.valid",   {31'b0, out_valid},  32'd0);
        check("mid_rst.pred_80", {31'b0, pred_taken}, 32'd0);
        check("mid_rst.perf_br", perf_branches,       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_branch_resolve_unit.md
# rv32_branch_resolve_unit

Pipelined branch resolution and prediction-training unit for the RV32IM core, the successor to the single-cycle combinational branch evaluator. It evaluates all six RV32 branch conditions and compares the outcome against the fetch-time prediction. It produces a registered taken/mispredict/redirect result behind a valid/ready handshake and trains a parametrised table of 2-bit saturating counters (BHT), which also serves fetch-side predictions. It sits between execute (resolve side) and the fetch/PC-select logic (predict and redirect side), and keeps wrapping performance counters.

## Interface
- XLEN, 32, data/PC width (from pkg_rv32_types)
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, ≥2; IDX_W = log2(BHT_ENTRIES)
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pred_pc  in  XLEN  fetch PC to predict
- pred_taken  out  1  combinational: MSB of BHT[pred_pc[IDX_W+1:2]]
- res_valid  in  1  branch to resolve is presented
- res_ready  out  1  unit accepts resolve request this cycle
- res_funct3  in  3  branch condition encoding
- res_rs1, res_rs2  in  XLEN  operands
- res_pc  in  XLEN  branch instruction PC
- res_target  in  XLEN  precomputed branch target (pc + imm)
- res_pred_taken  in  1  prediction made at fetch for this branch
- flush  in  1  discard the held result and refuse accepts this cycle
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes the result
- out_taken  out  1  resolved condition
- out_mispredict  out  1  out_taken != captured res_pred_taken
- out_redirect_pc  out  XLEN  out_taken ? target : pc + 4 (mod 2^XLEN)
- out_illegal  out  1  funct3 was 010 or 011
- perf_branches  out  32  legal branches accepted
- perf_mispredicts  out  32  legal mispredicted branches accepted

## Operation
- Conditions: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU. 010/011 are illegal: taken=0, mispredict=0, illegal=1, no BHT or perf update.
- Accept = res_valid & res_ready, where res_ready = !flush & (!out_valid | out_ready).
- On accept: the result register loads taken, mispredict, redirect_pc and illegal, and out_valid is set to 1.
- Otherwise:
  - if out_ready or flush, out_valid is set to 0;
  - else all out_* hold unchanged.
- BHT index = res_pc[IDX_W+1:2], the same slicing as pred_pc.
- BHT update, on accept of a legal branch only:
  - taken: counter+1, saturating at 2'b11;
  - not taken: counter−1, saturating at 2'b00.
- BHT states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = bit[1].
- Perf counters: perf_branches increments on every legal accept; perf_mispredicts increments additionally when the accepted branch mispredicts. Both wrap 0xFFFF_FFFF → 0.
- Reset values:
  - out_valid=0; out_taken=0; out_mispredict=0; out_illegal=0; out_redirect_pc=0;
  - all BHT entries=2'b01;
  - perf counters=0;
  - res_ready=0 while rst is high.
  - Reset asserted mid-operation drops any held result.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 branch/cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, res_ready=0 and out_* are stable.
- BHT read/write same cycle, same index: pred_taken shows the pre-update value. There is no bypass; the new value is visible next cycle.
- flush has priority over accept. Flush with out_ready=0 still clears out_valid next cycle.
- pred_taken is purely combinational from pred_pc and BHT state; no path from res_* to pred_taken within a cycle.

## Test plan
- Reset: hold rst 2 cycles → out_valid=0, perf counters=0. pred_pc=0x100 → pred_taken=0 (counter 01).
- All conditions: rs1=0xFFFF_FFFF, rs2=0x0000_0001 →
  - BEQ 0, BNE 1, BLT 1, BGE 0, BLTU 0, BGEU 1;
  - pc=0x200, target=0x180 → redirect 0x180 when taken, 0x204 otherwise.
- Training: four taken BEQ at pc=0x40 with rs1=rs2 → after the first, pred_pc=0x40 gives pred_taken=1; counter saturates at 11. Two not-taken → pred_taken=0 after the second.
- Mispredict/perf: res_pred_taken=0 on a taken BNE → out_mispredict=1; perf_branches=1, perf_mispredicts=1. A funct3=010 request → out_illegal=1 and counters unchanged.
- Backpressure/flush:
  - out_ready=0 for 3 cycles → res_ready=0 and out_* stable;
  - flush with out_valid=1 → out_valid=0 next cycle, and no accept in the flush cycle.
- Wrap/boundary:
  - res_pc=0xFFFF_FFFC not taken → redirect 0x0000_0000;
  - force perf_branches to 0xFFFF_FFFF, accept one legal branch → 0.
